// File: rtl/pulp_clock_divider.sv
// Programmable integer clock divider with a registered divided clock and a
// one-cycle tick. Divisor changes are applied only on period boundaries.
module pulp_clock_divider #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic [DIV_W-1:0] div_o,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic             bypass_o
);

  typedef enum logic [1:0] {
    BYPASS,
    IDLE,
    RUN
  } state_t;

  localparam logic [DIV_W-1:0] RESET_D     = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] TWO         = DIV_W'(2);
  localparam logic             RESET_BYP   = (RESET_DIV < 2);
  localparam state_t           RESET_STATE = RESET_BYP ? BYPASS : IDLE;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic [DIV_W-1:0] low_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             bypass_q, bypass_d;
  logic             accept;
  logic             apply;

  // Next-state logic; outputs are derived from the next counter and divisor
  // so that clk_div_o and tick_o come straight from flops.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    apply    = 1'b0;
    accept   = cfg_valid_i & ~pend_v_q;

    if (accept) begin
      pend_v_d = 1'b1;
      pend_d   = cfg_div_i;
    end

    case (state_q)
      BYPASS: apply = pend_v_q;
      IDLE: begin
        if (pend_v_q) begin
          apply = 1'b1;
        end else if (en_i) begin
          state_d = RUN;
          cnt_d   = {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (cnt_q == div_q - 1'b1) begin
          if (pend_v_q) begin
            apply = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = en_i ? RUN : IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    // A pending divisor always lands with the counter at the start of a low phase.
    if (apply) begin
      div_d    = pend_q;
      pend_v_d = 1'b0;
      cnt_d    = '0;
      if (pend_q < TWO) state_d = BYPASS;
      else if (en_i)    state_d = RUN;
      else              state_d = IDLE;
    end

    low_d    = div_d - (div_d >> 1);
    clk_d    = (state_d != BYPASS) && (cnt_d >= low_d);
    tick_d   = (state_d == RUN) && (cnt_d == low_d);
    bypass_d = (div_d < TWO);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RESET_STATE;
      div_q    <= RESET_D;
      cnt_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      bypass_q <= RESET_BYP;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      bypass_q <= bypass_d;
    end
  end

  assign cfg_ready_o = ~pend_v_q;
  assign div_o       = div_q;
  assign clk_div_o   = clk_q;
  assign tick_o      = tick_q;
  assign bypass_o    = bypass_q;

endmodule

// File: tb/tb_pulp_clock_divider.sv
// Self-checking bench for pulp_clock_divider: directed scenarios followed by
// random traffic, compared each cycle against a period-position model.
module tb_pulp_clock_divider;

  localparam int DIV_W     = 8;
  localparam int RESET_DIV = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic [DIV_W-1:0] cfg_div_i;
  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [DIV_W-1:0] div_o;
  logic             clk_div_o;
  logic             tick_o;
  logic             bypass_o;

  int checks = 0;
  int errors = 0;

  // Reference model: divisor, position inside the current period, run flag
  // and a queue holding the at-most-one pending divisor.
  int m_div;
  int m_pos;
  bit m_run;
  int m_pend[$];

  pulp_clock_divider #(
    .DIV_W    (DIV_W),
    .RESET_DIV(RESET_DIV)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .cfg_div_i  (cfg_div_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .div_o      (div_o),
    .clk_div_o  (clk_div_o),
    .tick_o     (tick_o),
    .bypass_o   (bypass_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    int  low;
    bit  byp;
    low = m_div - m_div / 2;
    byp = (m_div < 2);
    check_val({tag, "/div"},    32'(div_o),       32'(m_div));
    check_val({tag, "/bypass"}, 32'(bypass_o),    32'(byp));
    check_val({tag, "/ready"},  32'(cfg_ready_o), 32'(m_pend.size() == 0));
    check_val({tag, "/clk"},    32'(clk_div_o),   32'(!byp && m_pos >= low));
    check_val({tag, "/tick"},   32'(tick_o),      32'(m_run && m_pos == low));
  endtask

  // One source-clock edge of the behavioural model.
  task automatic model_edge(input bit rst, input bit en, input bit vin, input int din);
    bit accept;
    bit at_boundary;
    if (rst) begin
      m_div = RESET_DIV;
      m_pos = 0;
      m_run = 0;
      m_pend.delete();
      return;
    end
    accept      = vin && (m_pend.size() == 0);
    at_boundary = !m_run || (m_pos == m_div - 1);
    if (m_pend.size() != 0 && at_boundary) begin
      m_div = m_pend.pop_front();
      m_pos = 0;
      m_run = (m_div >= 2) && en;
    end else if (m_run) begin
      if (m_pos == m_div - 1) begin
        m_pos = 0;
        m_run = en;
      end else begin
        m_pos++;
      end
    end else if (m_div >= 2 && en) begin
      m_run = 1;
      m_pos = 1;
    end
    if (accept) m_pend.push_back(din);
  endtask

  // Drive inputs at the falling edge, advance one cycle, then compare at the
  // next falling edge.
  task automatic apply_stimulus(input bit rst, input bit en, input bit vin, input int din, input string tag);
    rst_i       = rst;
    en_i        = en;
    cfg_valid_i = vin;
    cfg_div_i   = DIV_W'(din);
    @(posedge clk_i);
    model_edge(rst, en, vin, din);
    @(negedge clk_i);
    check_output(tag);
  endtask

  initial begin
    int pat5[5];
    pat5 = '{0, 0, 0, 1, 1};
    rst_i = 1'b1; en_i = 1'b0; cfg_valid_i = 1'b0; cfg_div_i = '0;
    @(negedge clk_i);

    apply_stimulus(1, 0, 0, 0, "reset");
    check_val("reset_div",   32'(div_o),       32'(RESET_DIV));
    check_val("reset_clk",   32'(clk_div_o),   32'd0);
    check_val("reset_ready", 32'(cfg_ready_o), 32'd1);

    // D=2 toggles every cycle once enabled.
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(0, 1, 0, 0, "d2");
      check_val("d2_pattern", 32'(clk_div_o), 32'(k % 2));
      check_val("d2_tick",    32'(tick_o),    32'(k % 2));
    end
    // Let the period finish with en low, then load D=5 from IDLE.
    apply_stimulus(0, 0, 0, 0, "stop");
    apply_stimulus(0, 0, 1, 5, "cfg5_accept");
    apply_stimulus(0, 0, 0, 0, "cfg5_apply");
    check_val("cfg5_div", 32'(div_o), 32'd5);
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(0, 1, 0, 0, "d5");
      check_val("d5_pattern", 32'(clk_div_o), 32'(pat5[k % 5]));
    end

    // D=4 then update to D=3 mid-period, drop enable, and go to bypass and back.
    apply_stimulus(0, 1, 1, 4, "cfg4");
    for (int k = 0; k < 8; k++) apply_stimulus(0, 1, 0, 0, "d4");
    apply_stimulus(0, 1, 1, 3, "cfg3_mid");
    for (int k = 0; k < 8; k++) apply_stimulus(0, 1, 0, 0, "d3");
    apply_stimulus(0, 1, 1, 4, "cfg4b");
    for (int k = 0; k < 6; k++) apply_stimulus(0, 1, 0, 0, "d4b");
    for (int k = 0; k < 6; k++) apply_stimulus(0, 0, 0, 0, "d4_off");
    for (int k = 0; k < 6; k++) apply_stimulus(0, 1, 0, 0, "d4_on");
    apply_stimulus(0, 1, 1, 1, "cfg1");
    for (int k = 0; k < 6; k++) apply_stimulus(0, 1, 0, 0, "byp");
    check_val("byp_flag", 32'(bypass_o), 32'd1);
    apply_stimulus(0, 1, 1, 6, "cfg6");
    apply_stimulus(0, 1, 0, 0, "cfg6_apply");
    check_val("cfg6_byp", 32'(bypass_o), 32'd0);
    for (int k = 0; k < 8; k++) apply_stimulus(0, 1, 0, 0, "d6");

    // Reset while an update is pending discards it.
    apply_stimulus(0, 1, 1, 7, "cfg7");
    apply_stimulus(1, 1, 0, 0, "rst_pend");
    check_val("rst_pend_div",   32'(div_o),       32'(RESET_DIV));
    check_val("rst_pend_ready", 32'(cfg_ready_o), 32'd1);
    for (int k = 0; k < 4; k++) apply_stimulus(0, 0, 0, 0, "post_rst");

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      apply_stimulus($urandom_range(0, 199) == 0,
                     $urandom_range(0, 7) != 0,
                     $urandom_range(0, 3) == 0,
                     int'($urandom_range(0, 9)),
                     "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulp_clock_divider.md
Name: pulp_clock_divider

Overview:
- Programmable integer clock divider that feeds pulp_clock_mux2.
- Integration: clk_div_o drives mux clk0_i, the source clock drives mux clk1_i, and bypass_o drives mux sel_i.
- Produces a registered divided clock and a one-cycle tick. Divisor updates use a valid/ready handshake and take effect only on period boundaries, so the divided clock never produces a short phase.

Parameters:
- DIV_W, 8, width of the divisor.
- RESET_DIV, 2, divisor loaded at reset; values 0 or 1 mean bypass.

Ports:
- clk_i  in  1  source clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  run enable for the divided clock.
- cfg_div_i  in  DIV_W  new divisor D.
- cfg_valid_i  in  1  config request.
- cfg_ready_o  out  1  high when no update is pending; transfer occurs when cfg_valid_i & cfg_ready_o.
- div_o  out  DIV_W  divisor currently in effect (div_q).
- clk_div_o  out  1  divided clock, driven directly from a flop.
- tick_o  out  1  one-cycle pulse in the first high cycle of clk_div_o.
- bypass_o  out  1  1 when div_q < 2; goes to mux sel_i.

Behaviour:
- Reset (sync, rst_i=1 at edge):
  - div_q=RESET_DIV, cnt_q=0, clk_div_o=0, tick_o=0.
  - bypass_o=(RESET_DIV<2), cfg_ready_o=1.
  - Pending update discarded; state=BYPASS if RESET_DIV<2, else IDLE.
  - Reset has priority over all other events, including mid-update.
- Definitions: D=div_q; H=D>>1 (high cycles); L=D-H (low cycles). Low phase comes first.
- Output invariant, every cycle outside BYPASS:
  - clk_div_o == (cnt_q >= L).
  - tick_o == (state==RUN && cnt_q==L).
  - Both are registered, computed from cnt_d.
- State machine:
  - BYPASS (D<2): cnt_q=0, clk_div_o=0, tick_o=0, bypass_o=1. en_i is ignored.
  - IDLE (D>=2, stopped): cnt_q=0, clk_div_o=0. Goes to RUN at any edge where en_i=1 and no update is being applied; cnt_q becomes 1 at that edge (cycle with cnt_q=0 counts as the first low cycle).
  - RUN: cnt_q increments each edge and wraps from D-1 to 0. At the wrap edge, if en_i=0 the next state is IDLE, otherwise RUN continues.
- Period and duty: period = D clk_i cycles; high H, low L. For odd D the low phase is one cycle longer.
- Config handshake:
  - On accept, pend_q=cfg_div_i and pend_v=1, so cfg_ready_o=0 in the next cycle.
  - Apply point:
    - BYPASS/IDLE: the first edge where pend_v=1 (i.e. one cycle after accept).
    - RUN: the wrap edge (cnt_q==D-1).
  - On apply: div_q=pend_q, pend_v=0, cnt_q=0, clk_div_o=0. New state is BYPASS if the new D<2; otherwise RUN if en_i=1, else IDLE. cfg_ready_o=1 the cycle after apply.
  - An accept in the same cycle as a wrap is not applied at that wrap; it applies at the next boundary.
  - cfg_valid_i while cfg_ready_o=0 is ignored; the requester must hold valid.
- bypass_o and div_o change only at apply edges. bypass_o never changes while clk_div_o=1, which protects the downstream mux.
- D==0 is treated identically to D==1.
- Arithmetic: cnt_q is DIV_W bits wide; compares are unsigned.

Test Plan:
- RESET_DIV=2, en_i=1 after reset:
  - clk_div_o = 0,1,0,1…
  - tick_o high on every cycle with cnt_q=1.
  - bypass_o=0, cfg_ready_o=1.
- Config D=5 in IDLE, then en_i=1:
  - div_o=5 two cycles after accept.
  - clk_div_o repeats 0,0,0,1,1.
  - tick_o once every 5 cycles, on the 4th cycle of each period.
- RUN with D=4; accept D=3 at cnt_q=1:
  - cfg_ready_o=0 for cnt_q=2,3.
  - Old period completes (0,0,1,1).
  - Next period 0,0,1 with div_o=3; ready=1 in the cycle after the wrap.
- RUN with D=4; drop en_i at cnt_q=2:
  - clk_div_o stays 1 through cnt_q=3.
  - Then IDLE: clk_div_o=0 and no further tick.
  - Reassert en_i: the pattern restarts from cnt_q=0.
- RUN with D=4; configure D=1:
  - bypass_o rises only at the wrap edge, with clk_div_o=0.
  - Then configure D=6: bypass_o=0 two cycles after accept, counting resumes.
- Assert rst_i the cycle after accepting D=7 (pend_v=1):
  - div_o=RESET_DIV, cfg_ready_o=1, clk_div_o=0.
  - D=7 is never applied.
